// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one registered ALU among NREQ requesters.
// Define ALU_SCHED_STATS_EN to add the op_count completed-response counter port.
module alu_rr_sched #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [15:0]           op_count
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q;
    logic [IDW-1:0]   gnt_q;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [WIDTH-1:0] rsp_result_q;

    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;

    // Requester index base+off, wrapped modulo NREQ (off < NREQ).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    function automatic logic [WIDTH-1:0] alu(input logic [2:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
        logic shift_oob;
        shift_oob = (b >= WIDTH'(WIDTH));
        case (op)
            3'b000:  alu = a + b;
            3'b001:  alu = a - b;
            3'b010:  alu = a & b;
            3'b011:  alu = a | b;
            3'b100:  alu = a ^ b;
            3'b101:  alu = shift_oob ? '0 : (a << b);
            3'b110:  alu = shift_oob ? '0 : (a >> b);
            default: alu = a;
        endcase
    endfunction

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_found && req_valid[wrap_idx(rr_ptr_q, i)]) begin
                gnt_found = 1'b1;
                gnt_idx   = wrap_idx(rr_ptr_q, i);
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignment so all registers update together.
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (gnt_found) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = (state_q != IDLE);
        if (state_q == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr_q     <= '0;
            gnt_q        <= '0;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_found) begin
                    gnt_q <= gnt_idx;
                    op_q  <= req_op[3*int'(gnt_idx) +: 3];
                    a_q   <= req_a[WIDTH*int'(gnt_idx) +: WIDTH];
                    b_q   <= req_b[WIDTH*int'(gnt_idx) +: WIDTH];
                end
                EXEC: begin
                    rsp_result_q <= alu(op_q, a_q, b_q);
                    rsp_id_q     <= gnt_q;
                    rsp_valid_q  <= 1'b1;
                end
                // Pointer moves only on completion so the served requester drops to lowest priority.
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    rr_ptr_q    <= wrap_idx(gnt_q, 1);
                end
                default: ;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;

`ifdef ALU_SCHED_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge clock) begin
        if (reset)                          op_count_q <= '0;
        else if (rsp_valid_q && rsp_ready)  op_count_q <= op_count_q + 16'd1;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_rr_sched.sv
// Scoreboard bench for alu_rr_sched: driver pushes expected responses, a monitor pops and compares.
// Define ALU_SCHED_STATS_EN to also exercise the op_count port.
module tb_alu_rr_sched;

    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int WIDTH = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a, req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_result;
    logic                  busy;
`ifdef ALU_SCHED_STATS_EN
    logic [15:0]           op_count;
`endif

    alu_rr_sched #(.NREQ(NREQ), .IDW(IDW), .WIDTH(WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_result (rsp_result),
        .busy       (busy)
`ifdef ALU_SCHED_STATS_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] res;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_rsp = 0;
    int   last_rsp_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted response is compared against the head of the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_id", 32'(rsp_id), 32'(e.id));
                check("rsp_result", 32'(rsp_result), 32'(e.res));
            end
            n_rsp++;
            last_rsp_cyc = cyc;
        end
    end

    task automatic pulse_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic drive_req(input int id, input logic [2:0] op,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_valid[id]              = 1'b1;
        req_op[3*id +: 3]          = op;
        req_a[WIDTH*id +: WIDTH]   = a;
        req_b[WIDTH*id +: WIDTH]   = b;
    endtask

    task automatic wait_any_grant(output logic [NREQ-1:0] rdy, output int acc);
        rdy = '0;
        acc = cyc;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (req_ready != '0) begin
                rdy = req_ready;
                acc = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int target);
        for (int k = 0; k < 60; k++) begin
            @(posedge clock);
            if (n_rsp >= target) break;
        end
        check("rsp_count", 32'(n_rsp), 32'(target));
    endtask

    task automatic run_one(input int id, input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] res, output int acc);
        logic [NREQ-1:0] rdy;
        int base;
        base = n_rsp;
        exp_q.push_back('{id: IDW'(id), res: res});
        @(posedge clock); #1;
        drive_req(id, op, a, b);
        wait_any_grant(rdy, acc);
        check("grant_single", 32'(rdy), 32'(NREQ'(1) << id));
        @(posedge clock); #1;
        req_valid[id] = 1'b0;
        wait_rsp(base + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NREQ-1:0] rdy;
        int acc, prev, base;

        reset     = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_id", 32'(rsp_id), 32'd0);
        check("reset_rsp_result", 32'(rsp_result), 32'd0);
        check("reset_req_ready", 32'(req_ready), 32'd0);

        // Single request: grant in cycle 0, response in cycle 2, idle in cycle 3.
        run_one(1, 3'b000, 8'h7F, 8'h01, 8'h80, acc);
        check("single_latency", 32'(last_rsp_cyc - acc), 32'd2);
        @(negedge clock);
        check("single_idle_after", 32'(busy), 32'd0);

        // Wrap-around arithmetic and shift limits.
        run_one(2, 3'b000, 8'hFF, 8'h02, 8'h01, acc);
        run_one(2, 3'b001, 8'h00, 8'h01, 8'hFF, acc);
        run_one(2, 3'b101, 8'h01, 8'h08, 8'h00, acc);
        run_one(2, 3'b110, 8'h80, 8'h07, 8'h01, acc);
        run_one(0, 3'b010, 8'hF0, 8'h3C, 8'h30, acc);
        run_one(3, 3'b100, 8'hA5, 8'h0F, 8'hAA, acc);

        // Round-robin with all four requesters held valid.
        pulse_reset();
        base = n_rsp;
        @(posedge clock); #1;
        for (int i = 0; i < NREQ; i++) drive_req(i, 3'b000, WIDTH'(i * 16), 8'h01);
        for (int k = 0; k < 5; k++)
            exp_q.push_back('{id: IDW'(k % NREQ), res: WIDTH'((k % NREQ) * 16 + 1)});
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            wait_any_grant(rdy, acc);
            check("rr_grant", 32'(rdy), 32'(NREQ'(1) << (k % NREQ)));
            if (k > 0) check("rr_interval", 32'(acc - prev), 32'd3);
            prev = acc;
        end
        @(posedge clock); #1;
        req_valid = '0;
        wait_rsp(base + 5);

        // Backpressure: response held for five cycles, no new grant until the handshake.
        base = n_rsp;
        exp_q.push_back('{id: 2'd3, res: 8'hAA});
        exp_q.push_back('{id: 2'd1, res: 8'h3C});
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        drive_req(3, 3'b100, 8'hA5, 8'h0F);
        wait_any_grant(rdy, acc);
        check("bp_grant", 32'(rdy), 32'b1000);
        @(posedge clock); #1;
        req_valid[3] = 1'b0;
        drive_req(1, 3'b111, 8'h3C, 8'h00);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rsp_valid) break;
        end
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_id", 32'(rsp_id), 32'd3);
            check("bp_rsp_result", 32'(rsp_result), 32'hAA);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            if (k < 4) @(negedge clock);
        end
        @(posedge clock); #1;
        rsp_ready = 1'b1;
        @(negedge clock);
        check("bp_no_grant_in_handshake", 32'(req_ready), 32'd0);
        wait_any_grant(rdy, acc);
        check("bp_next_grant", 32'(rdy), 32'b0010);
        check("bp_next_grant_cycle", 32'(acc - last_rsp_cyc), 32'd1);
        @(posedge clock); #1;
        req_valid[1] = 1'b0;
        wait_rsp(base + 2);

        // Reset while a response is pending: dropped, pointer back to 0.
        base = n_rsp;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
        drive_req(2, 3'b010, 8'hF0, 8'h3C);
        wait_any_grant(rdy, acc);
        check("rst_pre_grant", 32'(rdy), 32'b0100);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (rsp_valid) break;
        end
        check("rst_pre_rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        rsp_ready = 1'b1;
        drive_req(0, 3'b011, 8'h0F, 8'hF0);
        exp_q.push_back('{id: 2'd0, res: 8'hFF});
        exp_q.push_back('{id: 2'd2, res: 8'h30});
        @(negedge clock);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant_req0", 32'(req_ready), 32'b0001);
        @(posedge clock); #1;
        req_valid[0] = 1'b0;
        wait_any_grant(rdy, acc);
        check("rst_second_grant", 32'(rdy), 32'b0100);
        @(posedge clock); #1;
        req_valid[2] = 1'b0;
        wait_rsp(base + 2);

`ifdef ALU_SCHED_STATS_EN
        pulse_reset();
        run_one(0, 3'b000, 8'h01, 8'h01, 8'h02, acc);
        run_one(1, 3'b011, 8'h10, 8'h01, 8'h11, acc);
        run_one(2, 3'b111, 8'h5A, 8'h00, 8'h5A, acc);
        @(negedge clock);
        check("stats_after_3", 32'(op_count), 32'd3);
        pulse_reset();
        @(negedge clock);
        check("stats_after_reset", 32'(op_count), 32'd0);
        run_one(3, 3'b001, 8'h05, 8'h03, 8'h02, acc);
        @(negedge clock);
        check("stats_after_1", 32'(op_count), 32'd1);
`endif

        repeat (2) @(negedge clock);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
